// File: rtl/pc_pkg.sv
// Shared constants and types for the next-PC selector and PC register.
package pc_pkg;

    // Source select codes for the default four-source build.
    localparam int SEL_SEQ = 0;
    localparam int SEL_BR  = 1;
    localparam int SEL_JR  = 2;
    localparam int SEL_EXC = 3;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam int          PC_INC_DEFAULT   = 4;

    // RUN: no redirect queued. PEND: one redirect held until the stall releases.
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } pc_state_e;

endpackage

// File: rtl/pc_src_sel.sv
// Combinational redirect-target selector over a flat source bus, with
// illegal-select detection and alignment force/check of the chosen target.
module pc_src_sel
    import pc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NSRC  = 4,
    parameter int ALIGN = 2,
    parameter int SELW  = $clog2(NSRC)
) (
    input  logic [SELW-1:0]             sel,
    input  logic [(NSRC-1)*WIDTH-1:0]   src_flat,
    output logic [WIDTH-1:0]            tgt,
    output logic                        illegal,
    output logic                        misaligned
);

    // Mask that clears the low ALIGN bits; also works for ALIGN = 0.
    localparam logic [WIDTH-1:0] ALIGN_MASK = {WIDTH{1'b1}} << ALIGN;

    logic [WIDTH-1:0] raw;
    logic             is_redirect;

    // Pick source k (1..NSRC-1); source 0 is the sequential path handled by the top.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so
        // no path through the if/for leaves a value unassigned and infers a latch.
        raw         = '0;
        is_redirect = 1'b0;
        illegal     = (int'(sel) >= NSRC);
        for (int k = 1; k < NSRC; k++) begin
            if (int'(sel) == k) begin
                raw         = src_flat[(k-1)*WIDTH +: WIDTH];
                is_redirect = 1'b1;
            end
        end
        tgt        = raw & ALIGN_MASK;
        misaligned = is_redirect && (|(raw & ~ALIGN_MASK));
    end

endmodule

// File: rtl/pc_next_reg.sv
// Next-PC selector with built-in PC register: sequential PC+INC or an external
// redirect, held on stall, with one redirect queued across a stall.
module pc_next_reg
    import pc_pkg::*;
#(
    parameter int              WIDTH    = 32,
    parameter int              NSRC     = 4,
    parameter int              INC      = PC_INC_DEFAULT,
    parameter int              ALIGN    = 2,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT),
    localparam int             SELW     = $clog2(NSRC)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      stall,
    input  logic [SELW-1:0]           sel,
    input  logic [(NSRC-1)*WIDTH-1:0] src_flat,
    output logic [WIDTH-1:0]          pc,
    output logic [WIDTH-1:0]          pc_inc,
    output logic                      redirected,
    output logic                      pending,
    output logic                      err_sel,
    output logic                      err_misalign
);

    pc_state_e        state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;
    logic             redir_q, redir_d;
    logic             err_sel_q, err_sel_d;
    logic             err_mis_q, err_mis_d;

    logic [WIDTH-1:0] tgt;
    logic             illegal;
    logic             misaligned;
    logic             take_redirect;

    pc_src_sel #(
        .WIDTH (WIDTH),
        .NSRC  (NSRC),
        .ALIGN (ALIGN),
        .SELW  (SELW)
    ) u_src_sel (
        .sel        (sel),
        .src_flat   (src_flat),
        .tgt        (tgt),
        .illegal    (illegal),
        .misaligned (misaligned)
    );

    // Sequential increment wraps naturally at the register width.
    assign pc_inc        = pc_q + WIDTH'(INC);
    assign take_redirect = (sel != '0) && !illegal;

    // Next-state and next-register values; illegal selects fall back to sequential.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_tgt_d = pend_tgt_q;
        redir_d    = redir_q;
        err_sel_d  = err_sel_q | illegal;
        err_mis_d  = err_mis_q;
        unique case (state_q)
            ST_RUN: begin
                if (!stall) begin
                    if (take_redirect) begin
                        pc_d      = tgt;
                        redir_d   = 1'b1;
                        err_mis_d = err_mis_q | misaligned;
                    end else begin
                        pc_d    = pc_inc;
                        redir_d = 1'b0;
                    end
                end else if (take_redirect) begin
                    pend_tgt_d = tgt;
                    state_d    = ST_PEND;
                    err_mis_d  = err_mis_q | misaligned;
                end
            end
            ST_PEND: begin
                // First queued request wins; sel is ignored until it is applied.
                if (!stall) begin
                    pc_d    = pend_tgt_q;
                    redir_d = 1'b1;
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // State register with synchronous reset; the queued target is cleared too.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking (<=) so every register samples
        // the pre-edge values regardless of statement order.
        if (reset) begin
            // NOTE: pend_tgt is an ordinary register, not a memory, and is reset
            // explicitly so a stale target can never leak out after reset.
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            pend_tgt_q <= '0;
            redir_q    <= 1'b0;
            err_sel_q  <= 1'b0;
            err_mis_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_tgt_q <= pend_tgt_d;
            redir_q    <= redir_d;
            err_sel_q  <= err_sel_d;
            err_mis_q  <= err_mis_d;
        end
    end

    assign pc           = pc_q;
    assign redirected   = redir_q;
    assign pending      = (state_q == ST_PEND);
    assign err_sel      = err_sel_q;
    assign err_misalign = err_mis_q;

endmodule

// File: tb/tb_pc_next_reg.sv
// Directed bench for pc_next_reg: a 4-source and a 3-source build share the
// same stimulus; expectations are queued when driven and checked after the edge.
module tb_pc_next_reg;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic [1:0]  sel = 2'd0;
    logic [31:0] src1 = '0, src2 = '0, src3 = '0;

    logic [95:0] src_flat4;
    logic [63:0] src_flat3;
    assign src_flat4 = {src3, src2, src1};
    assign src_flat3 = {src2, src1};

    logic [31:0] pc4, pc_inc4, pc3, pc_inc3;
    logic        rd4, pd4, es4, em4, rd3, pd3, es3, em3;

    pc_next_reg #(.NSRC(4)) dut4 (
        .clk(clk), .reset(reset), .stall(stall), .sel(sel), .src_flat(src_flat4),
        .pc(pc4), .pc_inc(pc_inc4), .redirected(rd4), .pending(pd4),
        .err_sel(es4), .err_misalign(em4)
    );

    pc_next_reg #(.NSRC(3)) dut3 (
        .clk(clk), .reset(reset), .stall(stall), .sel(sel), .src_flat(src_flat3),
        .pc(pc3), .pc_inc(pc_inc3), .redirected(rd3), .pending(pd3),
        .err_sel(es3), .err_misalign(em3)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          dut;
        string       tag;
        logic [31:0] pc;
        logic        rd;
        logic        pd;
        logic        es;
        logic        em;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, then compare after the edge.
    task automatic step(input logic r, input logic st, input logic [1:0] s, input int d,
                        input string tag, input logic [31:0] epc, input logic erd,
                        input logic epd, input logic ees, input logic eem);
        exp_t e, got;
        logic [31:0] opc, oinc;
        logic        ord, opd, oes, oem;
        reset = r;
        stall = st;
        sel   = s;
        e.dut = d; e.tag = tag; e.pc = epc; e.rd = erd; e.pd = epd; e.es = ees; e.em = eem;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        if (got.dut == 0) begin
            opc = pc4; oinc = pc_inc4; ord = rd4; opd = pd4; oes = es4; oem = em4;
        end else begin
            opc = pc3; oinc = pc_inc3; ord = rd3; opd = pd3; oes = es3; oem = em3;
        end
        check({got.tag, ".pc"},           opc,        got.pc);
        check({got.tag, ".pc_inc"},       oinc,       got.pc + 32'd4);
        check({got.tag, ".redirected"},   32'(ord),   32'(got.rd));
        check({got.tag, ".pending"},      32'(opd),   32'(got.pd));
        check({got.tag, ".err_sel"},      32'(oes),   32'(got.es));
        check({got.tag, ".err_misalign"}, 32'(oem),   32'(got.em));
    endtask

    initial begin
        // Four-source build: reset and sequential run.
        step(1, 0, 0, 0, "rst",      32'h0000_3000, 0, 0, 0, 0);
        step(0, 0, 0, 0, "seq1",     32'h0000_3004, 0, 0, 0, 0);
        step(0, 0, 0, 0, "seq2",     32'h0000_3008, 0, 0, 0, 0);
        step(0, 0, 0, 0, "seq3",     32'h0000_300C, 0, 0, 0, 0);

        // Branch redirect from 3008.
        step(1, 0, 0, 0, "rst2",     32'h0000_3000, 0, 0, 0, 0);
        step(0, 0, 0, 0, "seq4",     32'h0000_3004, 0, 0, 0, 0);
        step(0, 0, 0, 0, "seq5",     32'h0000_3008, 0, 0, 0, 0);
        src1 = 32'h0000_4000;
        step(0, 0, 1, 0, "br",       32'h0000_4000, 1, 0, 0, 0);
        step(0, 0, 0, 0, "br_seq",   32'h0000_4004, 0, 0, 0, 0);

        // Redirect queued during stall; later requests ignored.
        src2 = 32'h0000_5000;
        step(0, 1, 2, 0, "q_cap",    32'h0000_4004, 0, 1, 0, 0);
        src1 = 32'h0000_6000;
        step(0, 1, 1, 0, "q_hold1",  32'h0000_4004, 0, 1, 0, 0);
        step(0, 1, 1, 0, "q_hold2",  32'h0000_4004, 0, 1, 0, 0);
        step(0, 0, 1, 0, "q_rel",    32'h0000_5000, 1, 0, 0, 0);

        // Misaligned target is forced aligned and flagged; flag is sticky.
        src3 = 32'h0000_7002;
        step(0, 0, 3, 0, "misal",    32'h0000_7000, 1, 0, 0, 1);
        for (int i = 1; i <= 5; i++)
            step(0, 0, 0, 0, $sformatf("sticky%0d", i), 32'h0000_7000 + 32'(4 * i), 0, 0, 0, 1);

        // Wrap at the top of the address space.
        src1 = 32'hFFFF_FFF8;
        step(0, 0, 1, 0, "top",      32'hFFFF_FFF8, 1, 0, 0, 1);
        step(0, 0, 0, 0, "wrap1",    32'hFFFF_FFFC, 0, 0, 0, 1);
        step(0, 0, 0, 0, "wrap2",    32'h0000_0000, 0, 0, 0, 1);
        step(0, 0, 0, 0, "wrap3",    32'h0000_0004, 0, 0, 0, 1);

        // Three-source build: illegal select, reset out of PEND.
        step(1, 0, 0, 1, "n3_rst",      32'h0000_3000, 0, 0, 0, 0);
        step(0, 0, 3, 1, "n3_ill",      32'h0000_3004, 0, 0, 1, 0);
        src1 = 32'h0000_8000;
        step(0, 1, 1, 1, "n3_pend",     32'h0000_3004, 0, 1, 1, 0);
        step(1, 1, 1, 1, "n3_rst_pend", 32'h0000_3000, 0, 0, 0, 0);
        step(0, 0, 0, 1, "n3_release",  32'h0000_3004, 0, 0, 0, 0);

        // Illegal select while stalled, then misaligned capture into the queue.
        step(0, 1, 3, 1, "n3_ill_stall", 32'h0000_3004, 0, 0, 1, 0);
        src2 = 32'h0000_9001;
        step(0, 1, 2, 1, "n3_pend_mis", 32'h0000_3004, 0, 1, 1, 1);
        step(0, 0, 0, 1, "n3_rel_mis",  32'h0000_9000, 1, 0, 1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_next_reg.md
Name: pc_next_reg

Overview:
- Parametrised next-PC selector with the PC register built in, replacing the stand-alone three-way PC mux for the pipelined core.
- Selects among sequential PC+INC and NSRC-1 external redirect targets, then registers the result.
- Holds on stall and queues one redirect requested during a stall until the stall releases.
- Sits at the head of IF; drives the instruction-memory address and the IF/ID pipeline register.

Parameters:
- WIDTH, 32, address width.
- NSRC, 4, number of sources including the internal sequential source 0 (minimum 2).
- INC, 4, sequential increment.
- ALIGN, 2, number of low address bits that must be zero.
- RESET_PC, 32'h0000_3000, PC value after reset.
- SELW (localparam), $clog2(NSRC), select width.

Ports:
- clk, in, 1: clock; all state updates on the rising edge.
- reset, in, 1: synchronous, active-high reset.
- stall, in, 1: hold the PC this cycle.
- sel, in, SELW: source select. 0 = sequential; 1..NSRC-1 = redirect.
- src_flat, in, (NSRC-1)*WIDTH: redirect targets. Source k occupies bits [k*WIDTH-1 : (k-1)*WIDTH].
- pc, out, WIDTH: current PC (registered).
- pc_inc, out, WIDTH: pc+INC (combinational, modulo 2^WIDTH).
- redirected, out, 1: the last PC update was a non-sequential load.
- pending, out, 1: a redirect is queued.
- err_sel, out, 1: sticky flag, illegal select seen.
- err_misalign, out, 1: sticky flag, a misaligned target was loaded.

Behaviour:
- Reset, synchronous, active-high, evaluated at the rising edge of clk.
  - Outputs: pc=RESET_PC, redirected=0, pending=0, err_sel=0, err_misalign=0.
  - The pending target register is cleared.
  - Reset overrides stall and any queued redirect.
- State machine, two states:
  - RUN (pending=0).
  - PEND (pending=1, holds pend_tgt).
- Illegal select (sel >= NSRC): treated as sel=0 for next-PC purposes and sets err_sel. Applies in every state and regardless of stall.
- Target alignment: any redirect target is loaded with its low ALIGN bits forced to 0. If those bits were nonzero, err_misalign is set. The check happens when the target is captured, whether it goes to pc or to pend_tgt.
- RUN, stall=0 (one-cycle latency):
  - sel=0: pc <= pc+INC, redirected <= 0.
  - Legal sel k>0: pc <= aligned src[k], redirected <= 1.
- RUN, stall=1:
  - pc and redirected hold.
  - Legal sel k>0: pend_tgt <= aligned src[k], go to PEND.
  - sel=0: stay in RUN.
- PEND, stall=1:
  - pc, redirected and pend_tgt all hold.
  - New redirect requests are ignored; the first request wins.
- PEND, stall=0:
  - pc <= pend_tgt, redirected <= 1, go to RUN.
  - sel is ignored this cycle; the queued redirect takes priority.
- Arithmetic: pc+INC wraps modulo 2^WIDTH, e.g. 32'hFFFF_FFFC + 4 -> 0. No overflow flag.
- Sticky flags clear only on reset.
- Reset while in PEND discards the queued target.

Decomposition:
- Shared package pc_pkg:
  - SEL_SEQ=0, SEL_BR=1, SEL_JR=2, SEL_EXC=3.
  - RESET_PC_DEFAULT=32'h0000_3000.
  - PC_INC_DEFAULT=4.
  - State encoding ST_RUN=1'b0, ST_PEND=1'b1.
- One combinational sub-module, pc_src_sel:
  - NSRC-way flat-bus selector with illegal-select detect and alignment force/check.
  - Its outputs are tgt, illegal and misaligned.
- pc_next_reg contains the PC register, the PEND state machine and the sticky flags.

Test Plan:
- Reset then 3 cycles with sel=0, stall=0: pc = 3000, 3004, 3008, 300C; redirected=0; pc_inc = 3010 in the last cycle.
- From pc=3008, sel=1, src1=0000_4000 for one cycle: next pc=4000 with redirected=1. Next cycle with sel=0: pc=4004, redirected=0.
- Queued redirect:
  - stall=1 with sel=2, src2=0000_5000, then stall held 2 more cycles while sel=1, src1=6000.
  - pc holds throughout, pending=1.
  - Release stall with sel=1: pc=5000, pending=0, redirected=1.
- sel=3, src3=0000_7002, stall=0 (NSRC=4): pc=7000, err_misalign=1. The flag stays 1 after 5 further sequential cycles.
- NSRC=3 build, sel=3 at pc=3000: pc=3004, err_sel=1. Then in PEND (src1=8000) assert reset: pc=3000, pending=0, err_sel=0. Releasing stall afterwards gives pc=3004, not 8000.
- pc forced near the top via src1=FFFF_FFF8, then sequential: pc = FFFF_FFFC, 0000_0000, 0000_0004.
